servo_pwm_array: RTL and testbench

//  N-channel hobby-servo PWM generator with per-channel target width and slew-rate limiting.
//  All channels share one 1 us timebase and one frame counter.

---
 rtl/servo_pwm_array_if.sv | 14 +
 rtl/servo_pwm_array.sv | 97 +++++++++
 tb/tb_servo_pwm_array.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_array_if.sv
// servo_pwm_array_if: target-write bus for servo_pwm_array
//   wr_en  one-cycle write strobe
//   wr_ch  channel index (CW bits)
//   wr_us  requested pulse width in us (W bits)
interface servo_pwm_array_if #(
    parameter int CW = 3,
    parameter int W  = 16
);
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_us;
    modport master (output wr_en, wr_ch, wr_us);
    modport slave  (input  wr_en, wr_ch, wr_us);
endinterface

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: N-channel servo PWM with per-channel clamped targets and slew limiting
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       output enable, sampled at frame start
//   wr           target write bus (wr_en, wr_ch, wr_us)
//   pwm_out      registered PWM outputs, one per channel
//   cur_us       current slewed width per channel, ch i at [i*W +: W]
//   at_target    per-channel cur == target flag, registered
//   frame_start  one-cycle pulse as the frame counter wraps to 0
module servo_pwm_array #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int N_CH           = 5,
    parameter int W              = 16,
    parameter int FRAME_US       = 20000,
    parameter int MIN_US         = 1000,
    parameter int MAX_US         = 2000,
    parameter int INIT_US        = 1500,
    parameter int STEP_US        = 10,
    parameter int STEP_PERIOD_US = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    servo_pwm_array_if.slave      wr,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH*W-1:0]     cur_us,
    output logic [N_CH-1:0]       at_target,
    output logic                  frame_start
);
    localparam int CW  = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
    localparam logic [W-1:0] FRAME_TOP = W'(FRAME_US - 1);
    localparam logic [W-1:0] STEP_TOP  = W'(STEP_PERIOD_US - 1);
    localparam logic [W-1:0] MIN_W     = W'(MIN_US);
    localparam logic [W-1:0] MAX_W     = W'(MAX_US);
    localparam logic [W-1:0] INIT_W    = W'(INIT_US);
    localparam logic [W-1:0] STEP_W    = W'(STEP_US);

    logic [PW-1:0] pre;
    logic [W-1:0]  us_cnt, step_cnt, wr_clamped;
    logic          en_frame, us_tick, wrap, step_tick;
    logic [W-1:0]  target [N_CH];
    logic [W-1:0]  cur    [N_CH];
    logic [W-1:0]  shadow [N_CH];
    logic [W-1:0]  cur_nx [N_CH];

    assign us_tick    = pre == PRE_TOP;
    assign wrap       = us_tick && us_cnt == FRAME_TOP;
    assign step_tick  = us_tick && step_cnt == STEP_TOP;
    assign wr_clamped = wr.wr_us < MIN_W ? MIN_W : wr.wr_us > MAX_W ? MAX_W : wr.wr_us;

    // Step toward target by at most STEP_W; comparing the gap first keeps
    // every sum/difference inside W bits, so nothing can wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cur_nx[i] = cur[i] < target[i] ? (target[i] - cur[i] > STEP_W ? cur[i] + STEP_W : target[i])
                      : cur[i] > target[i] ? (cur[i] - target[i] > STEP_W ? cur[i] - STEP_W : target[i])
                      : cur[i];
            cur_us[i*W +: W] = cur[i];
        end
    end

    // Shadow and en_frame are latched on the wrap edge so the first cycle of
    // each frame already sees the new width; pwm_out lags us_cnt by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            us_cnt      <= '0;
            step_cnt    <= '0;
            en_frame    <= 1'b0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            at_target   <= '1;
            for (int i = 0; i < N_CH; i++) begin
                target[i] <= INIT_W;
                cur[i]    <= INIT_W;
                shadow[i] <= INIT_W;
            end
        end else begin
            pre         <= us_tick ? '0 : pre + 1'b1;
            frame_start <= wrap;
            if (us_tick) begin
                us_cnt   <= wrap ? '0 : us_cnt + 1'b1;
                step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            end
            if (wrap) en_frame <= enable;
            for (int i = 0; i < N_CH; i++) begin
                if (wr.wr_en && wr.wr_ch == CW'(i)) target[i] <= wr_clamped;
                if (step_tick) cur[i] <= cur_nx[i];
                if (wrap) shadow[i] <= cur[i];
                pwm_out[i]   <= en_frame && us_cnt < shadow[i];
                at_target[i] <= cur[i] == target[i];
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: directed bench for servo_pwm_array on a scaled timebase
// 2 clk per us, 100 us frame (200 clk), 50 us step period (100 clk), widths 40..80, init 60
module tb_servo_pwm_array;
    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [4:0]  pwm_out, at_target;
    logic [79:0] cur_us;
    logic        frame_start;
    int          total = 0, bad = 0;
    int          hi [5];

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] us;
        int          n;
        int          cc;
        logic [15:0] ec;
        logic [4:0]  ea;
    } vec_t;
    vec_t v [13];

    servo_pwm_array_if #(.CW(3), .W(16)) wr ();

    servo_pwm_array #(
        .CLK_HZ(2_000_000), .N_CH(5), .W(16), .FRAME_US(100), .MIN_US(40),
        .MAX_US(80), .INIT_US(60), .STEP_US(10), .STEP_PERIOD_US(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
        .pwm_out(pwm_out), .cur_us(cur_us), .at_target(at_target), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic check_reset(input string t);
        chk({t, "_pwm"}, 128'(pwm_out), 128'(0));
        chk({t, "_fs"}, 128'(frame_start), 128'(0));
        chk({t, "_at"}, 128'(at_target), 128'(5'b11111));
        chk({t, "_cur"}, 128'(cur_us), 128'({5{16'd60}}));
    endtask

    // Release reset at a negedge; first frame_start must come 200 clk later with no pulses before it.
    task automatic startup(input string t);
        int n = 0;
        logic [4:0] por = '0;
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
            por |= pwm_out;
        end while (!frame_start && n < 1000);
        chk({t, "_period"}, 128'(n), 128'(200));
        chk({t, "_frame0"}, 128'(por), 128'(0));
    endtask

    task automatic wait_frame(input string t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 400);
        chk({t, "_wait"}, 128'(frame_start), 128'(1));
    endtask

    // Called at the negedge where frame_start is high; counts high clocks per channel over one frame.
    task automatic measure(input int drop_at);
        for (int c = 0; c < 5; c++) hi[c] = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == drop_at) enable = 1'b0;
            for (int c = 0; c < 5; c++) hi[c] += int'(pwm_out[c]);
            @(negedge clk);
        end
    endtask

    task automatic chk_hi(input string t, input logic [79:0] e);
        for (int c = 0; c < 5; c++)
            chk($sformatf("%s_hi%0d", t, c), 128'(hi[c]), 128'(e[c*16 +: 16]));
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        wr.wr_en = 1'b0;
        wr.wr_ch = '0;
        wr.wr_us = '0;
        v[0]  = '{3'd2, 16'd80,  1, 2, 16'd70, 5'b11011};
        v[1]  = '{3'd7, 16'd0,   1, 2, 16'd80, 5'b11111};
        v[2]  = '{3'd0, 16'd10,  1, 0, 16'd50, 5'b11110};
        v[3]  = '{3'd7, 16'd0,   2, 0, 16'd40, 5'b11111};
        v[4]  = '{3'd0, 16'd200, 1, 0, 16'd50, 5'b11110};
        v[5]  = '{3'd7, 16'd0,   3, 0, 16'd80, 5'b11111};
        v[6]  = '{3'd3, 16'd65,  1, 3, 16'd65, 5'b11111};
        v[7]  = '{3'd7, 16'd0,   1, 3, 16'd65, 5'b11111};
        v[8]  = '{3'd7, 16'd45,  1, 4, 16'd60, 5'b11111};
        v[9]  = '{3'd4, 16'd79,  2, 4, 16'd79, 5'b11111};
        v[10] = '{3'd4, 16'd41,  1, 4, 16'd69, 5'b01111};
        v[11] = '{3'd7, 16'd0,   3, 4, 16'd41, 5'b11111};
        v[12] = '{3'd7, 16'd0,   1, 1, 16'd60, 5'b11111};

        repeat (3) @(negedge clk);
        check_reset("rst0");
        startup("t1");
        measure(-1);
        chk_hi("t1_f1", {5{16'd120}});
        @(negedge clk);

        // Each vector: write one cycle after a step, wait n steps, check one cycle after the last step.
        for (int i = 0; i < 13; i++) begin
            wr.wr_en = 1'b1;
            wr.wr_ch = v[i].ch;
            wr.wr_us = v[i].us;
            @(negedge clk);
            wr.wr_en = 1'b0;
            repeat (v[i].n * 100 - 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_cur", i), 128'(cur_us[v[i].cc*16 +: 16]), 128'(v[i].ec));
            chk($sformatf("v%0d_at", i), 128'(at_target), 128'(v[i].ea));
        end

        // Write ch1 = 70 on the step/frame edge: that step sees the old target.
        repeat (98) @(posedge clk);
        @(negedge clk);
        wr.wr_en = 1'b1;
        wr.wr_ch = 3'd1;
        wr.wr_us = 16'd70;
        @(negedge clk);
        wr.wr_en = 1'b0;
        chk("t5_fs", 128'(frame_start), 128'(1));
        chk("t5_cur_same", 128'(cur_us[16 +: 16]), 128'(60));
        measure(-1);
        chk_hi("t5_frame", {16'd82, 16'd130, 16'd160, 16'd120, 16'd160});
        chk("t5_cur_next", 128'(cur_us[16 +: 16]), 128'(70));
        chk("t5_at", 128'(at_target), 128'(5'b11111));
        measure(-1);
        chk_hi("t5_after", {16'd82, 16'd130, 16'd160, 16'd140, 16'd160});

        measure(50);
        chk_hi("t6_drop", {16'd82, 16'd130, 16'd160, 16'd140, 16'd160});
        measure(-1);
        chk_hi("t6_off", 80'd0);

        enable = 1'b1;
        wait_frame("t6");
        repeat (20) @(negedge clk);
        chk("t6_pre_rst", 128'(pwm_out), 128'(5'b11111));
        #1 rst_n = 1'b0;
        #1 check_reset("rst1");
        repeat (3) @(negedge clk);
        startup("t6r");
        measure(-1);
        chk_hi("t6r_f1", {5{16'd120}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
